// File: rtl/imgproc_ctrl.sv
// rtl/imgproc_ctrl.sv - command sequencer launching and tracking one image frame pass
// Optional idle-write watchdog is compiled in when IMGPROC_TIMEOUT_EN is defined.
module imgproc_ctrl #(
    parameter int WIDTH   = 320,
    parameter int HEIGHT  = 320,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cmd,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ack,
    input  logic       wr_strobe,
    output logic       start,
    output logic       abort,
    output logic [7:0] mode,
    output logic       busy,
    output logic       refresh,
    output logic       error
);

    localparam int N  = WIDTH * HEIGHT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [3:0] OP_NOP      = 4'd0;
    localparam logic [3:0] OP_SET_MODE = 4'd1;
    localparam logic [3:0] OP_START    = 4'd2;
    localparam logic [3:0] OP_ABORT    = 4'd3;
    localparam logic [3:0] OP_CLR_ERR  = 4'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            armed_q, armed_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ack_q, ack_d;
    logic            start_q, start_d;
    logic            abort_q, abort_d;
    logic [7:0]      mode_q, mode_d;
    logic            busy_q, busy_d;
    logic            refresh_q, refresh_d;
    logic            error_q, error_d;

    logic            accept;
    logic            set_err;
    logic            clr_err;
    logic            do_start;
    logic            do_abort;
    logic            frame_end;

`ifdef IMGPROC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]   idle_q, idle_d;
    logic            timed_out;

    always_comb begin
        idle_d    = '0;
        timed_out = 1'b0;
        if (state_q == S_RUN && !wr_strobe) begin
            idle_d    = idle_q + TW'(1);
            timed_out = (idle_q == TW'(TIMEOUT - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idle_q <= '0;
        else        idle_q <= idle_d;
    end
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        ack_d     = 1'b0;
        start_d   = 1'b0;
        abort_d   = 1'b0;
        refresh_d = 1'b0;
        mode_d    = mode_q;
        error_d   = error_q;
        set_err   = 1'b0;
        clr_err   = 1'b0;
        do_start  = 1'b0;
        do_abort  = 1'b0;
        frame_end = 1'b0;

        // DONE holds off acceptance so the pending command is taken once back in IDLE
        accept  = cmd_valid && armed_q && (state_q != S_DONE);
        armed_d = cmd_valid ? (armed_q && !accept) : 1'b1;

        if (accept) begin
            ack_d = 1'b1;
            case (cmd)
                OP_NOP:      ;
                OP_SET_MODE: if (state_q == S_RUN) set_err = 1'b1;
                             else mode_d = cmd_data;
                OP_START:    if (state_q == S_RUN) set_err = 1'b1;
                             else do_start = 1'b1;
                OP_ABORT:    do_abort = (state_q == S_RUN);
                OP_CLR_ERR:  clr_err = 1'b1;
                default:     set_err = 1'b1;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (do_start) begin
                    state_d = S_RUN;
                    count_d = '0;
                    start_d = 1'b1;
                end
            end
            S_RUN: begin
                frame_end = wr_strobe && (count_q == LAST);
                if (wr_strobe && !frame_end) count_d = count_q + CW'(1);
                // completion takes priority over a same-edge abort
                if (frame_end) begin
                    state_d   = S_DONE;
                    refresh_d = 1'b1;
                end else if (do_abort) begin
                    state_d = S_IDLE;
                    abort_d = 1'b1;
`ifdef IMGPROC_TIMEOUT_EN
                end else if (timed_out) begin
                    state_d = S_IDLE;
                    abort_d = 1'b1;
                    set_err = 1'b1;
`endif
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (set_err)      error_d = 1'b1;
        else if (clr_err) error_d = 1'b0;

        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            armed_q   <= 1'b1;
            count_q   <= '0;
            ack_q     <= 1'b0;
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
            mode_q    <= 8'h00;
            busy_q    <= 1'b0;
            refresh_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            count_q   <= count_d;
            ack_q     <= ack_d;
            start_q   <= start_d;
            abort_q   <= abort_d;
            mode_q    <= mode_d;
            busy_q    <= busy_d;
            refresh_q <= refresh_d;
            error_q   <= error_d;
        end
    end

    assign cmd_ack = ack_q;
    assign start   = start_q;
    assign abort   = abort_q;
    assign mode    = mode_q;
    assign busy    = busy_q;
    assign refresh = refresh_q;
    assign error   = error_q;

endmodule
